instr_issue: RTL and testbench



---
 rtl/instr_issue.sv | 172 +++++++++++++++++
 tb/tb_instr_issue.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue.sv
// Instruction decode/issue stage with its own 8x16 register file and one-cycle writeback.
// Optional build macro ISSUE_FWD_EN: forward ALUResult on RAW hazards instead of stalling.
module instr_issue #(
  parameter logic [4:0] NOP_CODE = 5'b11111
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] ins,
  input  logic        ins_valid,
  output logic        ins_ready,
  output logic [4:0]  ALUControl,
  output logic [15:0] SrcA,
  output logic [15:0] SrcB,
  output logic        issue,
  input  logic [15:0] ALUResult,
  output logic        wb_strobe,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  localparam logic [4:0] OP_INS    = 5'b00000;
  localparam logic [4:0] OP_DES    = 5'b00001;
  localparam logic [4:0] OP_CMP    = 5'b00100;
  localparam logic [4:0] OP_JUMP   = 5'b00101;
  localparam logic [4:0] OP_MOV    = 5'b00110;
  localparam logic [4:0] OP_AND    = 5'b01000;
  localparam logic [4:0] OP_SRA    = 5'b01110;
  localparam logic [4:0] OP_ADD    = 5'b10000;
  localparam logic [4:0] OP_SUBC   = 5'b10011;
  localparam logic [4:0] OP_ADD_I  = 5'b10100;
  localparam logic [4:0] OP_SUB_I  = 5'b10101;
  localparam logic [4:0] OP_ADD_II = 5'b10110;
  localparam logic [4:0] OP_SUB_II = 5'b10111;

  logic [4:0]  opc;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic [7:0]  imm8;

  logic [4:0]  dec_op;
  logic [15:0] dec_a;
  logic [15:0] dec_b;
  logic        dec_wb;
  logic        use_rd;
  logic        use_rs;
  logic        hit_rd;
  logic        hit_rs;
  logic [15:0] rd_val;
  logic [15:0] rs_val;
  logic        accept;

  logic        issue_q,    issue_d;
  logic [4:0]  alu_ctrl_q, alu_ctrl_d;
  logic [15:0] src_a_q,    src_a_d;
  logic [15:0] src_b_q,    src_b_d;
  logic        wb_en_q,    wb_en_d;
  logic [2:0]  wb_addr_q,  wb_addr_d;
  logic [15:0] regs_q [8];
  logic [15:0] regs_d [8];

  assign opc  = ins[15:11];
  assign rd   = ins[10:8];
  assign rs   = ins[7:5];
  assign imm8 = ins[7:0];

  assign wb_strobe = issue_q & wb_en_q;
  assign hit_rd    = wb_strobe && (wb_addr_q == rd);
  assign hit_rs    = wb_strobe && (wb_addr_q == rs);

`ifdef ISSUE_FWD_EN
  // The issuing ALU result is the value R[wb_addr] will hold after this edge.
  assign rd_val    = (use_rd && hit_rd) ? ALUResult : regs_q[rd];
  assign rs_val    = (use_rs && hit_rs) ? ALUResult : regs_q[rs];
  assign ins_ready = RST_N;
`else
  assign rd_val    = regs_q[rd];
  assign rs_val    = regs_q[rs];
  assign ins_ready = RST_N & ~((use_rd & hit_rd) | (use_rs & hit_rs));
`endif

  assign accept = ins_valid & ins_ready;

  always_comb begin
    dec_op = NOP_CODE;
    dec_a  = '0;
    dec_b  = '0;
    dec_wb = 1'b0;
    use_rd = 1'b0;
    use_rs = 1'b0;
    case (opc) inside
      OP_INS, OP_DES: begin
        dec_op = opc;
        use_rd = 1'b1;
        dec_a  = rd_val;
        dec_wb = 1'b1;
      end
      [OP_AND:OP_SRA], [OP_ADD:OP_SUBC]: begin
        dec_op = opc;
        use_rd = 1'b1;
        use_rs = 1'b1;
        dec_a  = rd_val;
        dec_b  = rs_val;
        dec_wb = 1'b1;
      end
      OP_CMP: begin
        dec_op = opc;
        use_rd = 1'b1;
        use_rs = 1'b1;
        dec_a  = rd_val;
        dec_b  = rs_val;
      end
      OP_ADD_I, OP_SUB_I: begin
        dec_op = opc;
        use_rd = 1'b1;
        dec_a  = rd_val;
        dec_b  = {8'h00, imm8};
        dec_wb = 1'b1;
      end
      OP_ADD_II, OP_SUB_II, OP_JUMP: begin
        dec_op = opc;
        dec_a  = {12'h000, ins[7:4]};
        dec_b  = {12'h000, ins[3:0]};
      end
      OP_MOV: begin
        dec_op = opc;
        dec_b  = {8'h00, imm8};
        dec_wb = 1'b1;
      end
      default: begin
        dec_op = NOP_CODE;
      end
    endcase
  end

  always_comb begin
    issue_d    = accept;
    alu_ctrl_d = accept ? dec_op : NOP_CODE;
    src_a_d    = accept ? dec_a : 16'h0000;
    src_b_d    = accept ? dec_b : 16'h0000;
    wb_en_d    = accept & dec_wb;
    wb_addr_d  = accept ? rd : 3'd0;
    for (int i = 0; i < 8; i++) regs_d[i] = regs_q[i];
    if (wb_strobe) regs_d[wb_addr_q] = ALUResult;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      issue_q    <= 1'b0;
      alu_ctrl_q <= NOP_CODE;
      src_a_q    <= '0;
      src_b_q    <= '0;
      wb_en_q    <= 1'b0;
      wb_addr_q  <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      issue_q    <= issue_d;
      alu_ctrl_q <= alu_ctrl_d;
      src_a_q    <= src_a_d;
      src_b_q    <= src_b_d;
      wb_en_q    <= wb_en_d;
      wb_addr_q  <= wb_addr_d;
      for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign issue      = issue_q;
  assign ALUControl = alu_ctrl_q;
  assign SrcA       = src_a_q;
  assign SrcB       = src_b_q;
  assign dbg_data   = regs_q[dbg_addr];

endmodule

// File: tb/tb_instr_issue.sv
// Bench for instr_issue: directed steps then random instructions against a sequential ISA model.
// Honours ISSUE_FWD_EN for the expected ready/stall behaviour.
module tb_instr_issue;

  localparam logic [4:0] NOP = 5'b11111;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] ins = '0;
  logic        ins_valid = 1'b0;
  logic        ins_ready;
  logic [4:0]  ALUControl;
  logic [15:0] SrcA, SrcB;
  logic        issue;
  logic [15:0] ALUResult;
  logic        wb_strobe;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int n_cmp = 0;
  int n_bad = 0;

  // m_arch: architectural registers in program order; m_rf: what the DUT file holds now
  logic [15:0] m_arch [8];
  logic [15:0] m_rf   [8];
  bit          pw_valid;
  logic [2:0]  pw_rd;
  logic [15:0] pw_val;

  instr_issue dut (
    .CLK(CLK), .RST_N(RST_N), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB), .issue(issue),
    .ALUResult(ALUResult), .wb_strobe(wb_strobe), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] tb_alu(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      5'b00000: return a + 16'd1;
      5'b00001: return a - 16'd1;
      5'b01000: return a & b;
      5'b01001: return a | b;
      5'b01010: return a ^ b;
      5'b01011: return a << b[3:0];
      5'b01100: return a >> b[3:0];
      5'b01101: return ~a;
      5'b01110: return 16'($signed(a) >>> b[3:0]);
      5'b00110: return b;
      5'b10000, 5'b10001, 5'b10100, 5'b10110, 5'b00101: return a + b;
      5'b10010, 5'b10011, 5'b10101, 5'b10111, 5'b00100: return a - b;
      default: return 16'h0000;
    endcase
  endfunction

  assign ALUResult = tb_alu(ALUControl, SrcA, SrcB);

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] rd, input logic [7:0] lo);
    return {op, rd, lo};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Decode from the instruction-set table using architectural register values.
  task automatic ref_decode(input logic [15:0] w, output logic [4:0] op, output logic [15:0] a,
                            output logic [15:0] b, output bit wb, output bit rrd, output bit rrs);
    logic [4:0] o;
    o = w[15:11];
    op = o; a = 16'h0; b = 16'h0; wb = 0; rrd = 0; rrs = 0;
    case (o) inside
      5'b00000, 5'b00001: begin a = m_arch[w[10:8]]; wb = 1; rrd = 1; end
      [5'b01000:5'b01110], [5'b10000:5'b10011]: begin
        a = m_arch[w[10:8]]; b = m_arch[w[7:5]]; wb = 1; rrd = 1; rrs = 1;
      end
      5'b00100: begin a = m_arch[w[10:8]]; b = m_arch[w[7:5]]; rrd = 1; rrs = 1; end
      5'b10100, 5'b10101: begin a = m_arch[w[10:8]]; b = {8'h00, w[7:0]}; wb = 1; rrd = 1; end
      5'b10110, 5'b10111, 5'b00101: begin a = {12'h0, w[7:4]}; b = {12'h0, w[3:0]}; end
      5'b00110: begin b = {8'h00, w[7:0]}; wb = 1; end
      default: op = NOP;
    endcase
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin m_arch[i] = '0; m_rf[i] = '0; end
    pw_valid = 0;
  endtask

  task automatic tick(input bit v, input logic [15:0] w, output bit acc);
    logic [4:0] eop; logic [15:0] ea, eb; bit ewb, rrd, rrs, eready;
    @(negedge CLK);
    ins_valid = v; ins = w; dbg_addr = 3'($urandom_range(0, 7));
    #1;
    chk("dbg_data", dbg_data, m_rf[dbg_addr]);
    ref_decode(w, eop, ea, eb, ewb, rrd, rrs);
`ifdef ISSUE_FWD_EN
    eready = 1;
`else
    eready = !(pw_valid && ((rrd && w[10:8] == pw_rd) || (rrs && w[7:5] == pw_rd)));
`endif
    if (v) chk("ins_ready", 16'(ins_ready), 16'(eready));
    acc = v && eready;
    @(posedge CLK);
    #1;
    if (pw_valid) m_rf[pw_rd] = pw_val;
    pw_valid = 0;
    if (!acc) begin eop = NOP; ea = '0; eb = '0; ewb = 0; end
    chk("ALUControl", 16'(ALUControl), 16'(eop));
    chk("SrcA", SrcA, ea);
    chk("SrcB", SrcB, eb);
    chk("issue", 16'(issue), 16'(acc));
    chk("wb_strobe", 16'(wb_strobe), 16'(ewb));
    if (ewb) begin
      pw_valid = 1; pw_rd = w[10:8]; pw_val = tb_alu(eop, ea, eb);
      m_arch[pw_rd] = pw_val;
    end
  endtask

  task automatic send(input logic [15:0] w, output int waits);
    bit acc;
    waits = 0;
    tick(1, w, acc);
    while (!acc && waits < 3) begin waits++; tick(1, w, acc); end
    if (!acc) begin
      n_cmp++; n_bad++;
      $error("FAIL accept_timeout observed=not_accepted expected=accepted ins=%h", w);
    end
    ins_valid = 0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(0, 16'($urandom), acc);
  endtask

  task automatic peek(input logic [2:0] a, input logic [15:0] exp, input string tag);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, exp_stall;
    model_reset();
    repeat (2) @(negedge CLK);
    RST_N = 1;

    // reset and load, with a pending writeback discarded by a mid-stream reset
    send(mk(5'b00110, 3'd6, 8'h77), w);
    @(negedge CLK); #2;
    RST_N = 0;
    #1;
    chk("rst_ALUControl", 16'(ALUControl), 16'(NOP));
    chk("rst_SrcA", SrcA, 16'h0);
    chk("rst_SrcB", SrcB, 16'h0);
    chk("rst_issue", 16'(issue), 16'h0);
    chk("rst_wb_strobe", 16'(wb_strobe), 16'h0);
    chk("rst_ins_ready", 16'(ins_ready), 16'h0);
    model_reset();
    for (int i = 0; i < 8; i++) peek(3'(i), 16'h0, "rst_dbg_data");
    @(negedge CLK);
    RST_N = 1;
    #1;
    chk("rel_ins_ready", 16'(ins_ready), 16'h1);
    send(mk(5'b00110, 3'd3, 8'h5A), w);
    idle(1);
    peek(3'd3, 16'h005A, "mov_r3");

    // immediate add
    send(mk(5'b00110, 3'd1, 8'h10), w);
    send(mk(5'b10100, 3'd1, 8'h05), w);
    chk("addi_SrcA", SrcA, 16'h0010);
    chk("addi_SrcB", SrcB, 16'h0005);
    idle(1);
    peek(3'd1, 16'h0015, "addi_r1");

    // back-to-back RAW hazard
    send(mk(5'b00110, 3'd4, 8'h01), w);
    send(mk(5'b00110, 3'd2, 8'h03), w);
    send(mk(5'b10000, 3'd4, {3'd2, 5'd0}), w);
`ifdef ISSUE_FWD_EN
    exp_stall = 0;
`else
    exp_stall = 1;
`endif
    chk("raw_stall_cycles", 16'(w), 16'(exp_stall));
    chk("raw_SrcB", SrcB, 16'h0003);
    idle(1);
    peek(3'd4, 16'h0004, "raw_r4");

    // no-writeback ops
    send(mk(5'b00100, 3'd1, {3'd2, 5'd0}), w);
    chk("cmp_wb_strobe", 16'(wb_strobe), 16'h0);
    send(mk(5'b10111, 3'd5, 8'h73), w);
    chk("subii_SrcA", SrcA, 16'h0007);
    chk("subii_SrcB", SrcB, 16'h0003);
    chk("subii_wb_strobe", 16'(wb_strobe), 16'h0);

    // JUMP and illegal opcode
    send(mk(5'b00101, 3'd2, 8'hA5), w);
    chk("jump_SrcA", SrcA, 16'h000A);
    chk("jump_SrcB", SrcB, 16'h0005);
    send(mk(5'b11000, 3'd3, 8'hFF), w);
    chk("ill_ALUControl", 16'(ALUControl), 16'(NOP));
    chk("ill_issue", 16'(issue), 16'h1);
    chk("ill_wb_strobe", 16'(wb_strobe), 16'h0);
    idle(1);
    for (int i = 0; i < 8; i++) peek(3'(i), m_arch[i], "nowb_regfile");

    // bubble between two ADDs
    send(mk(5'b10000, 3'd1, {3'd3, 5'd0}), w);
    idle(3);
    send(mk(5'b10000, 3'd1, {3'd1, 5'd0}), w);
    idle(1);
    peek(3'd1, 16'h00DE, "bubble_r1");

    // random stream with idle gaps
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else send(16'($urandom), w);
    end
    idle(2);
    for (int i = 0; i < 8; i++) peek(3'(i), m_arch[i], "final_regfile");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
